// File: rtl/bus_interface_unit.sv
// External-memory bus interface: single read/write transfers from the core,
// with fixed wait states, external ready handshake and bus-timeout error.
module bus_interface_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ab,
  output logic                  rw,
  output logic [DATA_WIDTH-1:0] dbo,
  output logic                  dboe,
  input  logic [DATA_WIDTH-1:0] dbi,
  input  logic                  rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic        TO_EN  = (TIMEOUT != 0);
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [7:0]  WLOAD  = 8'(WAIT_STATES);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ab_q;
  logic [DATA_WIDTH-1:0] dbo_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rw_q;
  logic                  dboe_q;
  logic                  busy_q;
  logic                  ack_q;
  logic                  err_q;
  logic [7:0]            wcnt_q;
  logic [TW-1:0]         tcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ab_q    <= '0;
      dbo_q   <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      dboe_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // Bus direction is set on the accept edge so it is valid throughout ADDR.
          if (req) begin
            ab_q    <= addr;
            dbo_q   <= wdata;
            rw_q    <= we;
            dboe_q  <= we;
            busy_q  <= 1'b1;
            state_q <= ADDR;
          end else begin
            state_q <= IDLE;
          end
        end
        ADDR: begin
          wcnt_q  <= WLOAD;
          tcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wcnt_q != 8'd0) begin
            wcnt_q <= wcnt_q - 8'd1;
          end else if (rdy) begin
            if (!rw_q) rdata_q <= dbi;
            rw_q    <= 1'b0;
            dboe_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else if (TO_EN && tcnt_q == TLIM) begin
            // tcnt_q counts earlier low samples, so this one is the TIMEOUT-th.
            rw_q    <= 1'b0;
            dboe_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (tcnt_q != '1) begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign ab    = ab_q;
  assign rw    = rw_q;
  assign dbo   = dbo_q;
  assign dboe  = dboe_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Scoreboard bench for bus_interface_unit: three instances with different
// wait-state / timeout settings, directed cases followed by random transfers.
module tb_bus_interface_unit;

  localparam int NI = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int WS [NI] = '{0, 2, 1};
  localparam int TO [NI] = '{255, 0, 4};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req   [NI];
  logic          we    [NI];
  logic [AW-1:0] addr  [NI];
  logic [DW-1:0] wdata [NI];
  logic          busy  [NI];
  logic          ack   [NI];
  logic          err   [NI];
  logic [DW-1:0] rdata [NI];
  logic [AW-1:0] ab    [NI];
  logic          rw    [NI];
  logic [DW-1:0] dbo   [NI];
  logic          dboe  [NI];
  logic [DW-1:0] dbi   [NI];
  logic          rdy   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_interface_unit #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .WAIT_STATES(WS[g]),
      .TIMEOUT    (TO[g])
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req[g]),
      .we   (we[g]),
      .addr (addr[g]),
      .wdata(wdata[g]),
      .busy (busy[g]),
      .ack  (ack[g]),
      .err  (err[g]),
      .rdata(rdata[g]),
      .ab   (ab[g]),
      .rw   (rw[g]),
      .dbo  (dbo[g]),
      .dboe (dboe[g]),
      .dbi  (dbi[g]),
      .rdy  (rdy[g])
    );
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int unsigned   ack_cyc;
  } exp_t;

  exp_t          sbq [NI][$];
  logic [DW-1:0] model_rdata [NI];
  bit            mon_en [NI];
  int unsigned   cyc = 0;
  int            nchk = 0;
  int            nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d] cyc %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks bus drive while busy.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        exp_t e;
        if (!mon_en[k]) continue;
        if (ack[k]) begin
          if (sbq[k].size() == 0) begin
            chk("spurious_ack", k, 1, 0);
          end else begin
            e = sbq[k].pop_front();
            chk("ack_cycle", k, cyc, e.ack_cyc);
            chk("err", k, err[k], e.err);
            chk("rdata", k, rdata[k], e.rdata);
            chk("ab_hold", k, ab[k], e.addr);
            chk("done_bus", k, {busy[k], rw[k], dboe[k]}, 0);
          end
        end else begin
          chk("err_no_ack", k, err[k], 0);
          if (busy[k]) begin
            if (sbq[k].size() == 0) begin
              chk("spurious_busy", k, 1, 0);
            end else begin
              e = sbq[k][0];
              chk("drive", k, {rw[k], dboe[k], ab[k], dbo[k]},
                  {e.we, e.we, e.addr, e.wdata});
            end
          end else begin
            chk("idle_dir", k, {rw[k], dboe[k]}, 0);
          end
        end
        if (sbq[k].size() > 0 && cyc > sbq[k][0].ack_cyc) begin
          chk("ack_missing", k, cyc, sbq[k][0].ack_cyc);
          void'(sbq[k].pop_front());
        end
      end
    end
  end

  // One transfer. L = rdy-low samples after the wait states; dfin = dbi on the completing edge.
  task automatic xfer(input int k, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int L, input logic [DW-1:0] dfin);
    exp_t e;
    int   lat;
    int   n;
    int   j;
    bit   to;
    to  = (TO[k] != 0) && (L >= TO[k]);
    lat = to ? (2 + WS[k] + TO[k] - 1) : (2 + WS[k] + L);
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = wd;
    n = 0;
    while (busy[k] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", k, n, 0);
      req[k] = 1'b0;
      return;
    end
    if (!w && !to) model_rdata[k] = dfin;
    e.we      = w;
    e.addr    = a;
    e.wdata   = wd;
    e.err     = to;
    e.rdata   = model_rdata[k];
    e.ack_cyc = cyc + 1 + lat;
    sbq[k].push_back(e);
    for (int s = 1; s <= lat; s++) begin
      @(negedge clk);
      if (s == 1) begin
        req[k]   = 1'b0;
        we[k]    = 1'($urandom);
        addr[k]  = AW'($urandom);
        wdata[k] = DW'($urandom);
      end
      j = s - 2 - WS[k];
      rdy[k] = (j < 0) ? 1'($urandom) : (j >= L);
      dbi[k] = (s == lat) ? dfin : DW'($urandom);
    end
  endtask

  task automatic gap(input int k, input int g);
    req[k] = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic run_random(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(0, 2);
      if (g > 0) gap(k, g);
      xfer(k, 1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 6), DW'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      dbi[k] = '0; rdy[k] = 1'b0; model_rdata[k] = '0; mon_en[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_state", k, {busy[k], ack[k], err[k], rw[k], dboe[k], rdata[k], ab[k]}, 0);
      chk("reset_dbo", k, dbo[k], 0);
    end
    #2 rst = 1'b1;
    @(negedge clk);

    fork
      begin
        xfer(0, 1'b0, 16'h1234, 8'h00, 0, 8'hA5);
        gap(0, 2);
        xfer(0, 1'b0, 16'h2000, 8'h00, 4, 8'h5A);
        gap(0, 1);
        xfer(0, 1'b0, 16'h0010, 8'h00, 0, 8'hC1);
        xfer(0, 1'b0, 16'h0011, 8'h00, 0, 8'hC2);
        run_random(0, 40);
      end
      begin
        xfer(1, 1'b0, 16'h0100, 8'h00, 0, 8'h99);
        gap(1, 1);
        xfer(1, 1'b1, 16'hFFFE, 8'h3C, 0, 8'hEE);
        gap(1, 1);
        xfer(1, 1'b0, 16'h0200, 8'h00, 6, 8'h42);
        run_random(1, 40);
      end
      begin
        xfer(2, 1'b0, 16'h0300, 8'h00, 0, 8'h11);
        gap(2, 1);
        xfer(2, 1'b0, 16'h0301, 8'h00, 10, 8'h22);
        gap(2, 1);
        xfer(2, 1'b0, 16'h0302, 8'h00, 3, 8'h33);
        gap(2, 1);
        xfer(2, 1'b1, 16'h0303, 8'h44, 4, 8'h55);
        run_random(2, 40);
      end
    join

    for (int k = 0; k < NI; k++) req[k] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
      @(negedge clk);
    end
    for (int k = 0; k < NI; k++) chk("drain", k, sbq[k].size(), 0);

    // Asynchronous reset in the middle of a write's wait phase on the W=2 instance.
    @(negedge clk);
    mon_en[1] = 1'b0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'hABCD; wdata[1] = 8'h77; rdy[1] = 1'b0;
    @(negedge clk);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_write", 1, {busy[1], rw[1], dboe[1]}, 3'b111);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_bus", 1, {rw[1], dboe[1], busy[1], ack[1]}, 0);
    chk("async_rst_ab", 1, ab[1], 0);
    chk("async_rst_dbo", 1, dbo[1], 0);
    for (int k = 0; k < NI; k++) chk("async_rst_rdata", k, rdata[k], 0);
    for (int k = 0; k < NI; k++) model_rdata[k] = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    mon_en[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_idle", 1, {busy[1], ack[1], err[1]}, 0);

    xfer(1, 1'b0, 16'h0042, 8'h00, 1, 8'h6B);
    repeat (4) @(negedge clk);
    chk("post_reset_xfer", 1, sbq[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
